// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction ROM port, branch redirect input and decode handshake.
// The master side is the fetch stage; the slave side is the ROM, execute and decode.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 20
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
    input  imem_rdata, br_taken, br_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
    output imem_rdata, br_taken, br_target, instr_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, 1-cycle ROM issue, prefetch queue, branch redirect.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 20,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_stage_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic               inflight_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [INSTR_W-1:0] q_instr_q [DEPTH];
  logic [PC_W-1:0]    q_pc_q    [DEPTH];

  logic               valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic               halt_push;
  logic [CNT_W:0]     credit;

  assign valid = (count_q != '0);
  assign pop   = valid & bus.instr_ready;

  // Occupancy after this edge if nothing new is issued; an issue is only allowed
  // when its response is guaranteed a free slot next cycle.
  assign credit = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue  = rst_n & ~bus.br_taken & (state_q == RUN) &
                  (credit < (CNT_W+1)'(DEPTH));

  // A response is dropped when a redirect flushes it or when it trails a halt word.
  assign push = inflight_q & ~bus.br_taken & (state_q == RUN);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_push = push & (bus.imem_rdata[INSTR_W-1 -: 4] == 4'hF);
`else
  assign halt_push = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (halt_push)    state_q <= HALT;
        HALT:    if (bus.br_taken) state_q <= RUN;
        default:                   state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= PC_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      if (bus.br_taken) begin
        pc_q <= bus.br_target;
      end else if (issue) begin
        pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.br_taken) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_instr_q[gi] <= '0;
          q_pc_q[gi]    <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          q_instr_q[gi] <= bus.imem_rdata;
          q_pc_q[gi]    <= inflight_pc_q;
        end
      end
    end
  endgenerate

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = q_instr_q[rd_ptr_q];
  assign bus.instr_pc    = q_pc_q[rd_ptr_q];
  assign bus.halted      = (state_q == HALT);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end for the 20-bit single-cycle core. It sits directly upstream of decode and the control unit.
- Owns the PC and issues word reads to a synchronous instruction ROM with fixed 1-cycle latency.
- Buffers returned words with their PC in a small prefetch queue, delivered to decode over a valid/ready handshake.
- Accepts branch redirects from execute: flushes stale work and restarts at the target.

Parameters:
- PC_W, 16: PC and ROM address width (word addressed).
- INSTR_W, 20: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
- DEPTH, 2: prefetch queue entries (power of two, >=2).
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  ROM read strobe.
- imem_addr  out  PC_W  ROM word address.
- imem_rdata  in  INSTR_W  ROM data, valid the cycle after imem_req.
- br_taken  in  1  redirect request from execute.
- br_target  in  PC_W  redirect address.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  PC_W  PC of head instruction.
- halted  out  1  fetch stopped on halt opcode (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - Queue empty: instr_valid=0, instr=0, instr_pc=0.
  - In-flight flag cleared; imem_req=0, imem_addr=RESET_PC; halted=0.
  - Reset mid-operation discards all queue and in-flight state immediately.
- Issue: imem_req=1 when rst_n=1, br_taken=0, halted=0 and count+inflight-pop < DEPTH. pop = instr_valid&instr_ready.
  - imem_addr=pc.
  - On issue, pc <= pc+1, modulo 2^PC_W (0xFFFF -> 0x0000).
- Response: the cycle after an issue, inflight=1.
  - At that edge, imem_rdata and its PC are written to the queue tail unless discarded.
  - The queue never overflows; the credit rule guarantees space.
- Output: registered queue with no bypass. instr/instr_pc show the head and hold stable while instr_valid=1 and instr_ready=0.
  - Pop on instr_valid&instr_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Latency and throughput:
  - Issue in cycle N, data in cycle N+1, instr_valid at cycle N+2.
  - With instr_ready held high, one instruction per cycle is sustained indefinitely.
- Redirect: br_taken=1 sampled at the end of cycle T.
  - Queue is flushed; any pop in T is ignored.
  - The response arriving in T is discarded.
  - No issue in T; pc <= br_target.
  - Cycle T+1 issues br_target; instr_valid=1 with instr_pc=br_target at T+3.
  - br_taken on consecutive cycles: the last target wins.
- Backpressure: instr_ready=0 with queue full gives imem_req=0 and pc frozen until a pop.
- State (FSM): RUN, HALT (HALT only reachable with the Optional Feature).
  - RUN -> HALT on a halt push.
  - HALT -> RUN on br_taken.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A pushed instruction whose opcode == 4'hF is enqueued normally and sets halted=1 at the same edge.
  - Issue stops; a response already in flight behind the halt word is discarded.
  - The queue still drains to decode.
  - br_taken clears halted and redirects normally.
- Undefined: opcode 4'hF is ordinary; halted tied 0; FSM stays in RUN.

Test Plan:
- Reset with ROM[0..3]=20'h10000..20'h13000 and ready=1 -> instr_valid first at cycle 2 after reset release; instr_pc 0,1,2,3 on consecutive cycles; instr matches the ROM words.
- Hold ready=0 for 5 cycles -> imem_req low after 2 words are queued; head stays pc=0; release -> pcs 0,1,2 in order, no loss or duplication.
- br_taken with br_target=16'h0040 while pcs 5 and 6 are queued/in flight -> 5 and 6 never appear; next instr_pc=0x0040 exactly 3 cycles after the br_taken cycle.
- RESET_PC=16'hFFFE, ready=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- With FETCH_HALT_DETECT_EN, ROM[2]=20'hF0000 -> pcs 0,1,2 delivered, halted=1, pc 3 never delivered; br_taken to 0x0010 -> halted=0, fetch resumes at 0x0010.
- Assert rst_n=0 mid-stream with 2 queued words -> instr_valid=0 immediately (async); after release, fetch restarts at RESET_PC.
